// File: rtl/tpu_mmio_pkg.sv
// Shared address map, region/state encodings and STATUS field layout for the
// tpuv1 MMIO bridge.
package tpu_mmio_pkg;

   localparam logic [31:0] A_BASE      = 32'h0000_0100;
   localparam logic [31:0] B_BASE      = 32'h0000_0200;
   localparam logic [31:0] C_BASE      = 32'h0000_0300;
   localparam logic [31:0] CMD_ADDR    = 32'h0000_0400;
   localparam logic [31:0] STATUS_ADDR = 32'h0000_0408;

   typedef enum logic [2:0] {
      REG_A,
      REG_B,
      REG_C,
      REG_CMD,
      REG_STATUS,
      REG_NONE
   } region_e;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RSP
   } state_e;

   localparam int ST_BUSY_BIT = 0;
   localparam int ST_REM_LSB  = 8;
   localparam int ST_REM_W    = 8;
   localparam int ST_DONE_LSB = 32;
   localparam int ST_DONE_W   = 16;
   localparam int ST_UNM_LSB  = 48;
   localparam int ST_UNM_W    = 16;

   // Region sizes come from the array geometry so the map tracks DIM/BITS_*.
   function automatic region_e decode_addr(input logic [31:0] addr,
                                           input logic [31:0] ab_bytes,
                                           input logic [31:0] c_bytes);
      region_e r;
      r = REG_NONE;
      if (addr[2:0] == 3'b000) begin
         if (addr >= A_BASE && addr < A_BASE + ab_bytes)      r = REG_A;
         else if (addr >= B_BASE && addr < B_BASE + ab_bytes) r = REG_B;
         else if (addr >= C_BASE && addr < C_BASE + c_bytes)  r = REG_C;
         else if (addr == CMD_ADDR)                           r = REG_CMD;
         else if (addr == STATUS_ADDR)                        r = REG_STATUS;
      end
      return r;
   endfunction

endpackage

// File: rtl/tpu_mmio_bridge_timer.sv
// Compute-window timer: a start pulse opens a COMPUTE_CYCLES-long busy window
// and each window that closes bumps a wrapping completion counter.
module tpu_compute_timer
   import tpu_mmio_pkg::*;
#(
   parameter int COMPUTE_CYCLES = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic [ST_REM_W-1:0]  remaining,
   output logic [ST_DONE_W-1:0] completed_count
);

   logic                 busy_q, busy_d;
   logic [ST_REM_W-1:0]  rem_q, rem_d;
   logic [ST_DONE_W-1:0] done_q, done_d;

   always_comb begin
      busy_d = busy_q;
      rem_d  = rem_q;
      done_d = done_q;
      if (start) begin
         busy_d = 1'b1;
         rem_d  = ST_REM_W'(COMPUTE_CYCLES);
      end else if (busy_q) begin
         rem_d = rem_q - 1'b1;
         // Busy drops in the same cycle remaining lands on zero.
         if (rem_q == ST_REM_W'(1)) begin
            busy_d = 1'b0;
            done_d = done_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         rem_q  <= '0;
         done_q <= '0;
      end else begin
         busy_q <= busy_d;
         rem_q  <= rem_d;
         done_q <= done_d;
      end
   end

   assign busy            = busy_q;
   assign remaining       = rem_q;
   assign completed_count = done_q;

endmodule

// File: rtl/tpu_mmio_bridge.sv
// Host valid/ready MMIO front end driving the tpuv1 addr/dataIn/r_w bus, with
// a fixed-latency read path, compute-window lockout and a local STATUS word.
module tpu_mmio_bridge
   import tpu_mmio_pkg::*;
#(
   parameter int BITS_AB        = 8,
   parameter int BITS_C         = 16,
   parameter int DIM            = 8,
   parameter int ADDRW          = 16,
   parameter int DATAW          = 64,
   parameter int READ_LAT       = 1,
   parameter int COMPUTE_CYCLES = DIM * 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             host_req_valid,
   output logic             host_req_ready,
   input  logic             host_req_wr,
   input  logic [ADDRW-1:0] host_req_addr,
   input  logic [DATAW-1:0] host_req_data,
   output logic             host_rsp_valid,
   input  logic             host_rsp_ready,
   output logic [DATAW-1:0] host_rsp_data,
   output logic [ADDRW-1:0] tpu_addr,
   output logic [DATAW-1:0] tpu_dataIn,
   output logic             tpu_r_w,
   input  logic [DATAW-1:0] tpu_dataOut
);

   localparam logic [31:0] AB_BYTES = 32'(DIM * DIM * BITS_AB / 8);
   localparam logic [31:0] C_BYTES  = 32'(DIM * DIM * BITS_C / 8);

   state_e               state_q, state_d;
   logic [2:0]           lat_q, lat_d;
   logic [DATAW-1:0]     rsp_data_q, rsp_data_d;
   logic [ADDRW-1:0]     tpu_addr_q, tpu_addr_d;
   logic [DATAW-1:0]     tpu_data_q, tpu_data_d;
   logic                 tpu_rw_q, tpu_rw_d;
   logic                 start_q, start_d;
   logic [ST_UNM_W-1:0]  unm_q, unm_d;

   region_e              region, eff_region;
   logic                 tpu_region, busy_any, req_ready, accept, unm_inc;
   logic                 tmr_busy;
   logic [ST_REM_W-1:0]  tmr_rem;
   logic [ST_DONE_W-1:0] tmr_done;
   logic [DATAW-1:0]     status_word;

   tpu_compute_timer #(
      .COMPUTE_CYCLES(COMPUTE_CYCLES)
   ) u_timer (
      .clk            (clk),
      .rst            (rst),
      .start          (start_q),
      .busy           (tmr_busy),
      .remaining      (tmr_rem),
      .completed_count(tmr_done)
   );

   // A CMD accepted last cycle has not reached the timer yet but already
   // closes the window, so a following A/B/C/CMD access cannot slip in.
   assign busy_any = tmr_busy | start_q;

   always_comb begin
      region     = decode_addr(32'(host_req_addr), AB_BYTES, C_BYTES);
      eff_region = region;
      if (host_req_wr && region == REG_STATUS) eff_region = REG_NONE;
      if (!host_req_wr && region == REG_CMD)   eff_region = REG_NONE;
      tpu_region = eff_region inside {REG_A, REG_B, REG_C, REG_CMD};
      req_ready  = !rst && (state_q == IDLE) && !(busy_any && tpu_region);
      accept     = host_req_valid && req_ready;
   end

   always_comb begin
      status_word                               = '0;
      status_word[ST_BUSY_BIT]                  = tmr_busy;
      status_word[ST_REM_LSB +: ST_REM_W]       = tmr_rem;
      status_word[ST_DONE_LSB +: ST_DONE_W]     = tmr_done;
      status_word[ST_UNM_LSB +: ST_UNM_W]       = unm_q;
   end

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      rsp_data_d = rsp_data_q;
      tpu_addr_d = '0;
      tpu_rw_d   = 1'b0;
      tpu_data_d = tpu_data_q;
      start_d    = 1'b0;
      unm_d      = unm_q;
      unm_inc    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               unm_inc = (eff_region == REG_NONE);
               if (host_req_wr) begin
                  if (tpu_region) begin
                     tpu_addr_d = host_req_addr;
                     tpu_data_d = host_req_data;
                     tpu_rw_d   = 1'b1;
                     start_d    = (eff_region == REG_CMD);
                  end
               end else if (eff_region inside {REG_A, REG_B, REG_C}) begin
                  state_d    = RD_WAIT;
                  tpu_addr_d = host_req_addr;
                  lat_d      = 3'(READ_LAT - 1);
               end else begin
                  state_d    = RSP;
                  rsp_data_d = (eff_region == REG_STATUS) ? status_word : '0;
               end
            end
         end
         RD_WAIT: begin
            tpu_addr_d = tpu_addr_q;
            if (lat_q == 3'd0) begin
               rsp_data_d = tpu_dataOut;
               tpu_addr_d = '0;
               state_d    = RSP;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         RSP: begin
            if (host_rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (unm_inc && unm_q != '1) unm_d = unm_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         lat_q      <= '0;
         rsp_data_q <= '0;
         tpu_addr_q <= '0;
         tpu_data_q <= '0;
         tpu_rw_q   <= 1'b0;
         start_q    <= 1'b0;
         unm_q      <= '0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         rsp_data_q <= rsp_data_d;
         tpu_addr_q <= tpu_addr_d;
         tpu_data_q <= tpu_data_d;
         tpu_rw_q   <= tpu_rw_d;
         start_q    <= start_d;
         unm_q      <= unm_d;
      end
   end

   assign host_req_ready = req_ready;
   assign host_rsp_valid = (state_q == RSP);
   assign host_rsp_data  = rsp_data_q;
   assign tpu_addr       = tpu_addr_q;
   assign tpu_dataIn     = tpu_data_q;
   assign tpu_r_w        = tpu_rw_q;

endmodule

// File: doc/tpu_mmio_bridge.md
Name: tpu_mmio_bridge

Overview:
Host-facing MMIO front end that sits directly upstream of tpuv1 and drives its addr/dataIn/r_w bus.
- Accepts valid/ready host requests and converts them into single-cycle tpuv1 bus writes, or fixed-latency tpuv1 reads with a held response.
- Enforces the compute window after a start command so A/B/C are not touched mid-computation.
- Exposes a local status register.

Parameters:
- BITS_AB, 8, A/B element width
- BITS_C, 16, C element width
- DIM, 8, systolic array dimension
- ADDRW, 16, MMIO address width
- DATAW, 64, MMIO data width
- READ_LAT, 1, cycles tpu_addr is held before tpu_dataOut is sampled (legal range 1-4)
- COMPUTE_CYCLES, 32, busy cycles after a start command (DIM*4)

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- host_req_valid  in  1  request valid
- host_req_ready  out  1  request accepted when valid&ready
- host_req_wr  in  1  1=write, 0=read
- host_req_addr  in  ADDRW  byte address
- host_req_data  in  DATAW  write data
- host_rsp_valid  out  1  read response valid
- host_rsp_ready  in  1  host takes response
- host_rsp_data  out  DATAW  read data
- tpu_addr  out  ADDRW  to tpuv1 addr
- tpu_dataIn  out  DATAW  to tpuv1 dataIn
- tpu_r_w  out  1  to tpuv1 r_w (1=write)
- tpu_dataOut  in  DATAW  from tpuv1 dataOut

Behaviour:
- One clock, clk; reset is synchronous and active-high, rst.
- Reset: tpu_addr=0, tpu_dataIn=0, tpu_r_w=0, host_rsp_valid=0, host_rsp_data=0, busy=0, all status counters 0, FSM=IDLE. host_req_ready=0 while rst=1.
- Reset asserted mid-read or mid-busy aborts everything. No response is issued afterward.
- Decode (only 8-byte aligned addresses are mapped):
  - A: 0x100-0x13F
  - B: 0x200-0x23F
  - C: 0x300-0x37F
  - CMD: 0x400 (write only)
  - STATUS: 0x408 (read only, local)
  - Anything else, including misaligned addresses, CMD reads and STATUS writes, is unmapped.
- Idle bus: tpu_addr=0, tpu_r_w=0, tpu_dataIn holds its last value.
- FSM states: IDLE, RD_WAIT, RSP.
- host_req_ready = (state==IDLE) && !(busy && decoded region is A/B/C/CMD). Ready may depend on addr/valid. STATUS and unmapped requests are accepted while busy.
- Write to A/B/C/CMD accepted in cycle T:
  - In T+1, tpu_addr=addr, tpu_dataIn=data, tpu_r_w=1 for exactly one cycle.
  - FSM stays in IDLE, so back-to-back writes run at one per cycle.
- CMD write additionally: busy=1 and remaining=COMPUTE_CYCLES from T+2. Remaining decrements each cycle; busy clears in the cycle it reaches 0. completed_count increments when busy falls.
- Read of A/B/C accepted in T: IDLE->RD_WAIT.
  - tpu_addr=addr, tpu_r_w=0 from T+1 through T+READ_LAT.
  - tpu_dataOut is captured at the end of T+READ_LAT; host_rsp_valid=1 from T+READ_LAT+1 (state RSP).
- STATUS or unmapped read accepted in T: straight to RSP with host_rsp_valid=1 in T+1; no tpu bus activity.
  - Unmapped reads return 0.
  - STATUS reads return bit0=busy, [15:8]=remaining, [47:32]=completed_count (wraps at 16 bits), [63:48]=unmapped_count.
- RSP: host_rsp_valid and host_rsp_data hold stable until host_rsp_ready. On the handshake cycle, go to IDLE. host_req_ready=0 while in RD_WAIT/RSP, so at most one read is outstanding.
- Unmapped write: dropped with no bus activity. unmapped_count increments on any unmapped access and saturates at 0xFFFF.
- A CMD write while busy is stalled via ready, never dropped.
- Simultaneous busy falling and an accept in the same cycle: ready is evaluated on the registered busy, so the accept happens one cycle later.

Decomposition:
- Package tpu_mmio_pkg:
  - address base/limit constants (A_BASE, B_BASE, C_BASE, CMD_ADDR, STATUS_ADDR)
  - region_e enum {REG_A, REG_B, REG_C, REG_CMD, REG_STATUS, REG_NONE}
  - state_e enum {IDLE, RD_WAIT, RSP}
  - STATUS field bit positions
- Sub-module tpu_compute_timer:
  - start input
  - busy, remaining and completed_count outputs
  - parameter COMPUTE_CYCLES

Test Plan:
- Reset, then STATUS read -> host_rsp_data=0 one cycle after accept; tpu_r_w stays 0.
- Write 0x0102030405060708 to 0x100, accepted in T -> in T+1 tpu_addr=0x100, tpu_dataIn=0x0102030405060708, tpu_r_w=1; tpu_r_w=0 in T+2.
- Read 0x308 with a tpuv1 model returning 0x1234, READ_LAT=1, host_rsp_ready=0 for 3 cycles -> host_rsp_valid rises at T+2 and data 0x1234 holds until the handshake; host_req_ready=0 throughout.
- CMD write at 0x400 then immediate write to 0x200 -> 0x200 accepted exactly 32 cycles after busy rises. STATUS read mid-window returns bit0=1 and decreasing [15:8]; after the window, [47:32]=1.
- Read 0x104 (misaligned) and write 0x500 -> read returns 0, no tpu bus activity, STATUS [63:48]=2.
- Assert rst during RD_WAIT and again mid-busy -> no host_rsp_valid afterwards; busy=0 and host_req_ready=1 one cycle after rst deasserts.
